// File: rtl/dma_job_scheduler.sv
// dma_job_scheduler
//   Round-robin front end for the DMA register block. Accepts jobs from
//   NUM_REQ requesters and runs one at a time: CONFIG write, CTRL write with
//   start, STATUS polling, TRANSFER_COUNT read, ERROR_STATUS clear, then a
//   one-cycle completion report.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i         per-requester job request, held until accepted
//   req_wcount_i        15-bit word count per requester (slice i = [15*i+:15])
//   req_cfg_i           9-bit CONFIG value per requester (slice i = [9*i+:9])
//   req_io_mem_i        CTRL io_mem bit per requester
//   req_ready_o         one-hot, one-cycle accept pulse
//   done_valid_o        one-cycle completion pulse
//   done_id_o           requester of the completed job
//   done_count_o        raw TRANSFER_COUNT read, 0 on timeout
//   done_err_o          job timed out
//   busy_o              high from accept through the completion pulse
//   wr_en_o, rd_en_o    DMA register write / read strobes
//   addr_o, wdata_o     DMA register address / write data (0 when idle)
//   rdata_i             DMA read data, valid the cycle after rd_en_o
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | wait for a request, pick one round-robin
// WR_CFG    | write CONFIG
// WR_CTRL   | write CTRL with start
// WAIT      | POLL_GAP idle cycles before the next STATUS read
// POLL_RD   | read STATUS
// POLL_CHK  | inspect STATUS: done, timed out, or poll again
// RD_CNT    | read TRANSFER_COUNT
// CNT_CHK   | capture TRANSFER_COUNT
// CLR_ERR   | write ERROR_STATUS clear mask
// REPORT    | completion pulse

module dma_job_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int POLL_GAP = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*15-1:0]      req_wcount_i,
    input  logic [NUM_REQ*9-1:0]       req_cfg_i,
    input  logic [NUM_REQ-1:0]         req_io_mem_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       done_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] done_id_o,
    output logic [31:0]                done_count_o,
    output logic                       done_err_o,
    output logic                       busy_o,
    output logic                       wr_en_o,
    output logic                       rd_en_o,
    output logic [31:0]                addr_o,
    output logic [31:0]                wdata_o,
    input  logic [31:0]                rdata_i
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int PCW = $clog2(TIMEOUT + 1);
    localparam int GW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [GW-1:0]  GAP_INIT  = GW'(POLL_GAP - 1);
    localparam logic [PCW-1:0] POLL_MAX  = PCW'(TIMEOUT);
    localparam logic [IW-1:0]  LAST_INIT = IW'(NUM_REQ - 1);

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0404;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0414;
    localparam logic [31:0] ADDR_TCOUNT = 32'h0000_0418;
    localparam logic [31:0] ADDR_ERRSTS = 32'h0000_0420;
    localparam logic [31:0] ADDR_CONFIG = 32'h0000_0424;
    localparam logic [31:0] ERR_CLR_ALL = 32'h0000_001F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CFG,
        S_WR_CTRL,
        S_WAIT,
        S_POLL_RD,
        S_POLL_CHK,
        S_RD_CNT,
        S_CNT_CHK,
        S_CLR_ERR,
        S_REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [IW-1:0]    id_q, id_d;
    logic [14:0]      wcount_q, wcount_d;
    logic [8:0]       cfg_q, cfg_d;
    logic             io_mem_q, io_mem_d;
    logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [31:0]      count_q, count_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] req_ready_d;
    logic               done_valid_d;
    logic [IW-1:0]      done_id_d;
    logic [31:0]        done_count_d;
    logic               done_err_d;
    logic               busy_d;
    logic               wr_en_d;
    logic               rd_en_d;
    logic [31:0]        addr_d;
    logic [31:0]        wdata_d;

    logic [14:0] wcount_arr [NUM_REQ];
    logic [8:0]  cfg_arr    [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wcount_arr[i] = req_wcount_i[15*i +: 15];
            cfg_arr[i]    = req_cfg_i[9*i +: 9];
        end
    end

    // Round-robin: first valid requester after the last one granted.
    logic [IW-1:0] grant;
    logic          grant_vld;

    always_comb begin
        int idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_vld && req_valid_i[IW'(idx)]) begin
                grant     = IW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wcount_d     = wcount_q;
        cfg_d        = cfg_q;
        io_mem_d     = io_mem_q;
        poll_cnt_d   = poll_cnt_q;
        gap_d        = gap_q;
        count_d      = count_q;
        err_d        = err_q;
        req_ready_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready_d[grant] = 1'b1;
                    last_grant_d       = grant;
                    id_d               = grant;
                    wcount_d           = wcount_arr[grant];
                    cfg_d              = cfg_arr[grant];
                    io_mem_d           = req_io_mem_i[grant];
                    poll_cnt_d         = '0;
                    count_d            = '0;
                    err_d              = 1'b0;
                    state_d            = S_WR_CFG;
                end
            end
            S_WR_CFG:  state_d = S_WR_CTRL;
            S_WR_CTRL: begin
                gap_d   = GAP_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (gap_q == '0) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_POLL_RD: begin
                poll_cnt_d = poll_cnt_q + PCW'(1);
                state_d    = S_POLL_CHK;
            end
            S_POLL_CHK: begin
                // STATUS[1] = done, STATUS[0] = busy
                if (rdata_i[1] && !rdata_i[0]) begin
                    state_d = S_RD_CNT;
                end else if (poll_cnt_q == POLL_MAX) begin
                    err_d   = 1'b1;
                    count_d = '0;
                    state_d = S_CLR_ERR;
                end else begin
                    gap_d   = GAP_INIT;
                    state_d = S_WAIT;
                end
            end
            S_RD_CNT:  state_d = S_CNT_CHK;
            S_CNT_CHK: begin
                count_d = rdata_i;
                state_d = S_CLR_ERR;
            end
            S_CLR_ERR: state_d = S_REPORT;
            S_REPORT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        addr_d       = '0;
        wdata_d      = '0;
        done_valid_d = 1'b0;
        done_id_d    = '0;
        done_count_d = '0;
        done_err_d   = 1'b0;
        busy_d       = (state_d != S_IDLE);

        case (state_d)
            S_WR_CFG: begin
                wr_en_d = 1'b1;
                addr_d  = ADDR_CONFIG;
                wdata_d = {23'h0, cfg_d};
            end
            S_WR_CTRL: begin
                wr_en_d = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = {15'h0, io_mem_d, wcount_d, 1'b1};
            end
            S_POLL_RD: begin
                rd_en_d = 1'b1;
                addr_d  = ADDR_STATUS;
            end
            S_RD_CNT: begin
                rd_en_d = 1'b1;
                addr_d  = ADDR_TCOUNT;
            end
            S_CLR_ERR: begin
                wr_en_d = 1'b1;
                addr_d  = ADDR_ERRSTS;
                wdata_d = ERR_CLR_ALL;
            end
            S_REPORT: begin
                done_valid_d = 1'b1;
                done_id_d    = id_d;
                done_count_d = count_d;
                done_err_d   = err_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_INIT;
            id_q         <= '0;
            wcount_q     <= '0;
            cfg_q        <= '0;
            io_mem_q     <= 1'b0;
            poll_cnt_q   <= '0;
            gap_q        <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            req_ready_o  <= '0;
            done_valid_o <= 1'b0;
            done_id_o    <= '0;
            done_count_o <= '0;
            done_err_o   <= 1'b0;
            busy_o       <= 1'b0;
            wr_en_o      <= 1'b0;
            rd_en_o      <= 1'b0;
            addr_o       <= '0;
            wdata_o      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wcount_q     <= wcount_d;
            cfg_q        <= cfg_d;
            io_mem_q     <= io_mem_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_q        <= gap_d;
            count_q      <= count_d;
            err_q        <= err_d;
            req_ready_o  <= req_ready_d;
            done_valid_o <= done_valid_d;
            done_id_o    <= done_id_d;
            done_count_o <= done_count_d;
            done_err_o   <= done_err_d;
            busy_o       <= busy_d;
            wr_en_o      <= wr_en_d;
            rd_en_o      <= rd_en_d;
            addr_o       <= addr_d;
            wdata_o      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_dma_job_scheduler.sv
// tb_dma_job_scheduler
//   Table of single jobs with hand-computed bus and completion values, then
//   hand-written sequences for held round-robin requests and reset mid-job.
//   A small DMA model answers STATUS after a programmable latency (or never,
//   when stuck) and returns wcount+1 from TRANSFER_COUNT.

module tb_dma_job_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int POLL_GAP = 2;
    localparam int TIMEOUT  = 4;

    localparam logic [31:0] A_CTRL   = 32'h0000_0404;
    localparam logic [31:0] A_STATUS = 32'h0000_0414;
    localparam logic [31:0] A_TC     = 32'h0000_0418;
    localparam logic [31:0] A_ERR    = 32'h0000_0420;
    localparam logic [31:0] A_CONFIG = 32'h0000_0424;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [59:0] req_wcount = '0;
    logic [35:0] req_cfg = '0;
    logic [3:0]  req_io_mem = '0;
    logic [3:0]  req_ready;
    logic        done_valid;
    logic [1:0]  done_id;
    logic [31:0] done_count;
    logic        done_err;
    logic        busy;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    dma_job_scheduler #(
        .NUM_REQ (NUM_REQ),
        .POLL_GAP(POLL_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_wcount_i(req_wcount),
        .req_cfg_i   (req_cfg),
        .req_io_mem_i(req_io_mem),
        .req_ready_o (req_ready),
        .done_valid_o(done_valid),
        .done_id_o   (done_id),
        .done_count_o(done_count),
        .done_err_o  (done_err),
        .busy_o      (busy),
        .wr_en_o     (wr_en),
        .rd_en_o     (rd_en),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .rdata_i     (rdata)
    );

    always #5 clk = ~clk;

    // ---------------- DMA model ----------------
    int          lat_cfg   = 4;
    bit          stuck_cfg = 1'b0;
    int          dma_cnt   = 0;
    logic        dma_act   = 1'b0;
    logic [14:0] dma_wc    = '0;
    wire         dma_done  = dma_act && (dma_cnt == 0);

    always @(posedge clk) begin
        if (wr_en && addr == A_CTRL && wdata[0]) begin
            dma_act <= 1'b1;
            dma_cnt <= lat_cfg;
            dma_wc  <= wdata[15:1];
        end else if (dma_act && dma_cnt != 0 && !stuck_cfg) begin
            dma_cnt <= dma_cnt - 1;
        end
        if (rd_en) begin
            if (addr == A_STATUS)  rdata <= {30'h0, dma_done, !dma_done};
            else if (addr == A_TC) rdata <= 32'(dma_wc) + 32'd1;
            else                   rdata <= 32'hDEAD_BEEF;
        end
    end

    // ---------------- bus monitor ----------------
    int          cyc = 0;
    int          last_ctrl_cyc = -100;
    int          mon_polls = 0;
    int          mon_tc = 0;
    int          mon_clr = 0;
    int          mon_done = 0;
    int          mon_bad = 0;
    logic [31:0] mon_cfg_w = '0;
    logic [31:0] mon_ctrl_w = '0;

    always @(negedge clk) begin
        if (wr_en && rd_en) begin
            mon_bad++;
        end else if (wr_en) begin
            case (addr)
                A_CONFIG: mon_cfg_w = wdata;
                A_CTRL: begin
                    mon_ctrl_w    = wdata;
                    last_ctrl_cyc = cyc;
                end
                A_ERR: begin
                    mon_clr++;
                    if (wdata != 32'h1F) mon_bad++;
                end
                default: mon_bad++;
            endcase
        end else if (rd_en) begin
            case (addr)
                A_STATUS: begin
                    mon_polls++;
                    if (cyc - last_ctrl_cyc < POLL_GAP + 1) mon_bad++;
                end
                A_TC:    mon_tc++;
                default: mon_bad++;
            endcase
        end else if (addr != '0 || wdata != '0) begin
            mon_bad++;
        end
        if (!$onehot0(req_ready)) mon_bad++;
        if (done_valid) mon_done++;
        cyc++;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  mask;
        int          lat;
        bit          stuck;
        logic [3:0]  exp_ready;
        logic [31:0] exp_cfg_w;
        logic [31:0] exp_ctrl_w;
        int          exp_polls;
        logic [31:0] exp_count;
        logic        exp_err;
    } vec_t;

    vec_t vt [10];

    task automatic wait_ready(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
    endtask

    task automatic wait_done(input int budget, output bit busy_ok);
        busy_ok = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done_valid) break;
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int p0, c0, t0;
        bit bok;
        string tg;
        tg = $sformatf("v%0d", n);
        p0 = mon_polls;
        c0 = mon_clr;
        t0 = mon_tc;
        lat_cfg   = v.lat;
        stuck_cfg = v.stuck;
        req_valid = v.mask;
        wait_ready(20);
        check({tg, "_ready"}, 32'(req_ready), 32'(v.exp_ready));
        check({tg, "_busy_at_accept"}, 32'(busy), 32'd1);
        req_valid = '0;
        wait_done(200, bok);
        check({tg, "_done_valid"}, 32'(done_valid), 32'd1);
        check({tg, "_busy_held"}, 32'(bok), 32'd1);
        check({tg, "_done_id"}, 32'(done_id), 32'($clog2(32'(v.exp_ready))));
        check({tg, "_done_count"}, done_count, v.exp_count);
        check({tg, "_done_err"}, 32'(done_err), 32'(v.exp_err));
        check({tg, "_cfg_wdata"}, mon_cfg_w, v.exp_cfg_w);
        check({tg, "_ctrl_wdata"}, mon_ctrl_w, v.exp_ctrl_w);
        check({tg, "_status_reads"}, 32'(mon_polls - p0), 32'(v.exp_polls));
        check({tg, "_tc_reads"}, 32'(mon_tc - t0), v.exp_err ? 32'd0 : 32'd1);
        check({tg, "_err_clears"}, 32'(mon_clr - c0), 32'd1);
        check({tg, "_bus"}, 32'(mon_bad), 32'd0);
        @(negedge clk);
        check({tg, "_idle_after"}, {30'h0, busy, done_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   bok;
        int   d0;
        logic [1:0] exp_id;

        // requester 3..0
        req_wcount = {15'h1234, 15'h7FFF, 15'h0000, 15'h0005};
        req_cfg    = {9'h033, 9'h100, 9'h1FF, 9'h0A5};
        req_io_mem = 4'b0101;

        //          mask     lat stk ready    CONFIG wdata   CTRL wdata     polls count          err
        vt[0] = '{4'b0001,  4, 0, 4'b0001, 32'h0000_00A5, 32'h0001_000B, 2, 32'h0000_0006, 1'b0};
        vt[1] = '{4'b0010,  4, 0, 4'b0010, 32'h0000_01FF, 32'h0000_0001, 2, 32'h0000_0001, 1'b0};
        vt[2] = '{4'b1111, 12, 0, 4'b0100, 32'h0000_0100, 32'h0001_FFFF, 4, 32'h0000_8000, 1'b0};
        vt[3] = '{4'b1111,  4, 0, 4'b1000, 32'h0000_0033, 32'h0000_2469, 2, 32'h0000_1235, 1'b0};
        vt[4] = '{4'b1001,  4, 1, 4'b0001, 32'h0000_00A5, 32'h0001_000B, 4, 32'h0000_0000, 1'b1};
        vt[5] = '{4'b1001,  1, 0, 4'b1000, 32'h0000_0033, 32'h0000_2469, 1, 32'h0000_1235, 1'b0};
        vt[6] = '{4'b0110,  8, 0, 4'b0010, 32'h0000_01FF, 32'h0000_0001, 3, 32'h0000_0001, 1'b0};
        vt[7] = '{4'b0101,  4, 0, 4'b0100, 32'h0000_0100, 32'h0001_FFFF, 2, 32'h0000_8000, 1'b0};
        vt[8] = '{4'b0011,  4, 0, 4'b0001, 32'h0000_00A5, 32'h0001_000B, 2, 32'h0000_0006, 1'b0};
        vt[9] = '{4'b1100,  4, 1, 4'b0100, 32'h0000_0100, 32'h0001_FFFF, 4, 32'h0000_0000, 1'b1};

        // reset state, with requests already pending
        req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_strobes", {28'h0, wr_en, rd_en, busy, done_valid}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_done", {29'h0, done_id, done_err}, 32'd0);
        check("rst_done_count", done_count, 32'd0);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

        // all requests held: order 0,1,2,3,0 after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat_cfg   = 4;
        stuck_cfg = 1'b0;
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            exp_id = 2'(j % 4);
            wait_ready(20);
            check($sformatf("rr%0d_ready", j), 32'(req_ready), 32'(4'b0001 << exp_id));
            wait_done(200, bok);
            check($sformatf("rr%0d_done_valid", j), 32'(done_valid), 32'd1);
            check($sformatf("rr%0d_busy_held", j), 32'(bok), 32'd1);
            check($sformatf("rr%0d_done_id", j), 32'(done_id), 32'(exp_id));
            if (j == 4) req_valid = '0;
            @(negedge clk);
            check($sformatf("rr%0d_gap", j), {30'h0, busy, |req_ready}, 32'd0);
        end
        check("rr_bus", 32'(mon_bad), 32'd0);

        // reset during POLL_CHK with req0 and req1 pending
        stuck_cfg = 1'b1;
        req_valid = 4'b0001;
        wait_ready(20);
        check("mr_first_ready", 32'(req_ready), 32'b0001);
        req_valid = 4'b0011;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_en && addr == A_STATUS) break;
        end
        check("mr_saw_poll", 32'(rd_en && addr == A_STATUS), 32'd1);
        d0 = mon_done;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mr_async_strobes", {27'h0, wr_en, rd_en, busy, done_valid, done_err}, 32'd0);
        check("mr_async_ready", 32'(req_ready), 32'd0);
        check("mr_async_addr", addr, 32'd0);
        check("mr_async_wdata", wdata, 32'd0);
        check("mr_async_done", {done_count[31:2], done_count[1:0] | done_id}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stuck_cfg = 1'b0;
        lat_cfg   = 4;
        wait_ready(20);
        check("mr_ready_after_rst", 32'(req_ready), 32'b0001);
        check("mr_no_done", 32'(mon_done - d0), 32'd0);
        req_valid = '0;
        wait_done(200, bok);
        check("mr_done_valid", 32'(done_valid), 32'd1);
        check("mr_done_id", 32'(done_id), 32'd0);
        check("mr_done_count", done_count, 32'd6);
        check("mr_done_err", 32'(done_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("final_bus", 32'(mon_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
